// File: rtl/k005297_pkg.sv
// Shared defaults and mode encodings for the K005297 page shift register slice.
package k005297_pkg;

  localparam int unsigned DW_DEFAULT  = 12;
  localparam int unsigned NCH_DEFAULT = 4;

  typedef enum logic {
    BIT_LSBF = 1'b0,
    BIT_MSBF = 1'b1
  } bit_order_e;

  typedef enum logic {
    FILL_ZERO   = 1'b0,
    FILL_RECIRC = 1'b1
  } fill_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/k005297_pgreg_file.sv
// NCH x DW page register file: synchronous write port, combinational read mux
// that always returns the contents from before this cycle's write.
module k005297_pgreg_file
  import k005297_pkg::*;
#(
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned NCH  = NCH_DEFAULT,
  parameter int unsigned SELW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            we,
  input  logic [SELW-1:0] wsel,
  input  logic [DW-1:0]   wdata,
  input  logic [SELW-1:0] rsel,
  output logic [DW-1:0]   rdata,
  output logic [DW-1:0]   page0
);

  logic [DW-1:0] page_q [NCH];
  logic [DW-1:0] page_d [NCH];

  // Next contents: selected page replaced on a write strobe.
  always_comb begin
    page_d = page_q;
    if (we) page_d[wsel] = wdata;
  end

  // Page storage, cleared by reset, updated only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) page_q[i] <= '0;
    end else if (en) begin
      page_q <= page_d;
    end
  end

  // Reads come from the registered array, so a same-cycle write is not visible.
  always_comb begin
    rdata = page_q[rsel];
    page0 = page_q[0];
  end

endmodule

// File: rtl/k005297_pgsr_multi.sv
// Page register file plus serialising shift register with start/stop window,
// selectable bit order and fill, bit counter with auto-stop, deferred loads.
module k005297_pgsr_multi
  import k005297_pkg::*;
#(
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned NCH  = NCH_DEFAULT,
  parameter int unsigned SELW = 2,
  parameter int unsigned CNTW = 5
) (
  input  logic            i_MCLK,
  input  logic            i_SYS_RST,
  input  logic            i_CLK2M_PCEN_n,
  input  logic            i_PGREG_LD,
  input  logic [SELW-1:0] i_PGREG_WSEL,
  input  logic [15:0]     i_DIN,
  input  logic [SELW-1:0] i_PGREG_RSEL,
  input  logic            i_PGREG_SR_LD_EN,
  input  logic            i_SHIFT_START,
  input  logic            i_SHIFT_STOP,
  input  logic            i_MODE_MSBF,
  input  logic            i_MODE_RECIRC,
  output logic [DW-1:0]   o_PGREG0_Q,
  output logic            o_PGREG_SR_SHIFT,
  output logic            o_PGREG_SR_BIT,
  output logic [CNTW-1:0] o_PGREG_SR_CNT,
  output logic            o_PGREG_SR_DONE,
  output logic            o_PGREG_LD_PEND
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DW - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DW);

  logic            en;
  shift_state_e    state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            pend_q, pend_d;
  logic [SELW-1:0] psel_q, psel_d;
  logic [SELW-1:0] rd_sel;
  logic [DW-1:0]   rd_data;
  logic            ser_bit;
  logic            fill_bit;
  bit_order_e      order;
  fill_mode_e      fmode;
  logic            unused_din;

  assign en         = ~i_CLK2M_PCEN_n;
  assign unused_din = ^i_DIN;

  k005297_pgreg_file #(
    .DW   (DW),
    .NCH  (NCH),
    .SELW (SELW)
  ) u_pgreg_file (
    .clk   (i_MCLK),
    .rst   (i_SYS_RST),
    .en    (en),
    .we    (i_PGREG_LD),
    .wsel  (i_PGREG_WSEL),
    .wdata (i_DIN[DW-1:0]),
    .rsel  (rd_sel),
    .rdata (rd_data),
    .page0 (o_PGREG0_Q)
  );

  // Serial tap and fill bit follow the live mode inputs; a fresh load request
  // takes the read port ahead of any captured deferred select.
  always_comb begin
    order    = bit_order_e'(i_MODE_MSBF);
    fmode    = fill_mode_e'(i_MODE_RECIRC);
    ser_bit  = (order == BIT_MSBF) ? sr_q[DW-1] : sr_q[0];
    fill_bit = (fmode == FILL_RECIRC) ? ser_bit : 1'b0;
    rd_sel   = i_PGREG_SR_LD_EN ? i_PGREG_RSEL : psel_q;
  end

  // Next-state: shift/count/auto-stop while in the window, load/start otherwise.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    psel_d  = psel_q;
    unique case (state_q)
      ST_SHIFT: begin
        sr_d = (order == BIT_MSBF) ? {sr_q[DW-2:0], fill_bit}
                                   : {fill_bit, sr_q[DW-1:1]};
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        if (i_SHIFT_STOP) state_d = ST_IDLE;
        if (i_PGREG_SR_LD_EN) begin
          pend_d = 1'b1;
          psel_d = i_PGREG_RSEL;
        end
      end
      default: begin
        if (i_PGREG_SR_LD_EN || pend_q) begin
          sr_d   = rd_data;
          cnt_d  = '0;
          pend_d = 1'b0;
        end
        if (i_SHIFT_START && !i_SHIFT_STOP) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State registers: reset on any edge, otherwise advance only when enabled.
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      psel_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      psel_q  <= psel_d;
    end
  end

  // Output mapping.
  always_comb begin
    o_PGREG_SR_SHIFT = (state_q == ST_SHIFT);
    o_PGREG_SR_BIT   = ser_bit;
    o_PGREG_SR_CNT   = cnt_q;
    o_PGREG_SR_DONE  = done_q;
    o_PGREG_LD_PEND  = pend_q;
  end

endmodule

// File: tb/tb_k005297_pgsr_multi.sv
// Bench for k005297_pgsr_multi: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the page register / shifter.
module tb_k005297_pgsr_multi;

  localparam int DW   = 12;
  localparam int MASK = 'hFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1, pcen_n = 1'b0, ld = 1'b0, lden = 1'b0;
  logic        start = 1'b0, stop = 1'b0, msbf = 1'b0, recirc = 1'b0;
  logic [1:0]  wsel = '0, rsel = '0;
  logic [15:0] din = '0;

  logic [11:0] pg0;
  logic        sh, sbit, done, pend;
  logic [4:0]  cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int m_page [4];
  int m_old  [4];
  int m_sr, m_cnt, m_psel, m_b, m_f;
  bit m_shift, m_pend, m_done;

  k005297_pgsr_multi #(.DW(12), .NCH(4), .SELW(2), .CNTW(5)) dut (
    .i_MCLK           (clk),
    .i_SYS_RST        (rst),
    .i_CLK2M_PCEN_n   (pcen_n),
    .i_PGREG_LD       (ld),
    .i_PGREG_WSEL     (wsel),
    .i_DIN            (din),
    .i_PGREG_RSEL     (rsel),
    .i_PGREG_SR_LD_EN (lden),
    .i_SHIFT_START    (start),
    .i_SHIFT_STOP     (stop),
    .i_MODE_MSBF      (msbf),
    .i_MODE_RECIRC    (recirc),
    .o_PGREG0_Q       (pg0),
    .o_PGREG_SR_SHIFT (sh),
    .o_PGREG_SR_BIT   (sbit),
    .o_PGREG_SR_CNT   (cnt),
    .o_PGREG_SR_DONE  (done),
    .o_PGREG_LD_PEND  (pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_bit();
    return msbf ? ((m_sr >> (DW - 1)) & 1) : (m_sr & 1);
  endfunction

  // Model: page array and shift register as plain integers.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_page[i] = 0;
      m_sr = 0; m_cnt = 0; m_psel = 0;
      m_shift = 0; m_pend = 0; m_done = 0;
    end else if (!pcen_n) begin
      for (int i = 0; i < 4; i++) m_old[i] = m_page[i];
      m_b = model_bit();
      if (ld) m_page[wsel] = din & MASK;
      m_done = 0;
      if (m_shift) begin
        m_f = recirc ? m_b : 0;
        if (msbf) m_sr = ((m_sr * 2) & MASK) | m_f;
        else      m_sr = (m_sr / 2) | (m_f << (DW - 1));
        m_cnt = (m_cnt < DW) ? m_cnt + 1 : DW;
        if (m_cnt == DW) begin m_shift = 0; m_done = 1; end
        if (stop) m_shift = 0;
        if (lden) begin m_pend = 1; m_psel = rsel; end
      end else begin
        if (lden)        begin m_sr = m_old[rsel];   m_cnt = 0; m_pend = 0; end
        else if (m_pend) begin m_sr = m_old[m_psel]; m_cnt = 0; m_pend = 0; end
        if (start && !stop) begin m_shift = 1; m_cnt = 0; end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pg0",  pg0,  m_page[0]);
      check("shift", sh,  m_shift);
      check("bit",  sbit, model_bit());
      check("cnt",  cnt,  m_cnt);
      check("done", done, m_done);
      check("pend", pend, m_pend);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    ld = 0; lden = 0; start = 0; stop = 0;
  endtask

  int exp1 [12] = '{0,0,1,1,1,0,1,0,0,1,0,1};
  int exp2 [12] = '{1,0,1,0,0,1,0,1,1,1,0,0};
  int dones, n;

  initial begin
    // Reset
    rst = 1; cyc(); cyc();
    rst = 0; chk_en = 1;
    check("rst_cnt", cnt, 0);
    check("rst_shift", sh, 0);
    check("rst_pend", pend, 0);
    check("rst_done", done, 0);
    check("rst_pg0", pg0, 0);

    // LSB first, zero fill
    ld = 1; wsel = 1; din = 16'h0A5C; cyc();
    lden = 1; rsel = 1; start = 1; msbf = 0; recirc = 0; cyc();
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      check("t1_bit", sbit, exp1[i]);
      cyc();
      if (done) dones++;
    end
    check("t1_cnt", cnt, 12);
    check("t1_shift", sh, 0);
    check("t1_done", done, 1);
    cyc();
    if (done) dones++;
    check("t1_done_once", dones, 1);
    check("t1_model_sr", m_sr, 0);
    check("t1_bit_zero", sbit, 0);

    // MSB first, recirculate, then shift the result back out LSB first
    msbf = 1; recirc = 1; lden = 1; rsel = 1; start = 1; cyc();
    for (int i = 0; i < 12; i++) begin
      check("t2_bit", sbit, exp2[i]);
      cyc();
    end
    check("t2_cnt", cnt, 12);
    check("t2_model_sr", m_sr, 'hA5C);
    msbf = 0; recirc = 0; start = 1; cyc();
    for (int i = 0; i < 12; i++) begin
      check("t2_reshift", sbit, exp1[i]);
      cyc();
    end

    // Deferred load mid-shift
    ld = 1; wsel = 2; din = 16'h03C7; cyc();
    lden = 1; rsel = 1; start = 1; msbf = 0; cyc();
    repeat (5) cyc();
    check("t3_cnt5", cnt, 5);
    lden = 1; rsel = 2; cyc();
    check("t3_pend", pend, 1);
    check("t3_still_shift", sh, 1);
    n = 0;
    while (sh && n < 20) begin cyc(); n++; end
    check("t3_autostop", sh, 0);
    check("t3_cnt12", cnt, 12);
    check("t3_pend_held", pend, 1);
    cyc();
    check("t3_pend_clr", pend, 0);
    check("t3_cnt0", cnt, 0);
    msbf = 1; recirc = 0; start = 1; cyc();
    for (int i = 0; i < 12; i++) begin
      check("t3_page2_bit", sbit, ('h3C7 >> (11 - i)) & 1);
      cyc();
    end

    // START with STOP, then early STOP
    start = 1; stop = 1; cyc();
    check("t4_startstop", sh, 0);
    start = 1; cyc();
    repeat (6) cyc();
    check("t4_cnt6", cnt, 6);
    stop = 1; cyc();
    check("t4_cnt7", cnt, 7);
    check("t4_stopped", sh, 0);
    repeat (3) cyc();
    check("t4_cnt_hold", cnt, 7);
    check("t4_no_done", done, 0);

    // Enable held high blocks everything; reset ignores the enable
    ld = 1; wsel = 0; din = 16'h05A5; cyc();
    pcen_n = 1;
    repeat (3) begin
      ld = 1; wsel = 0; din = 16'h0000; lden = 1; start = 1; cyc();
    end
    check("t5_pg0_hold", pg0, 'h5A5);
    check("t5_cnt_hold", cnt, 7);
    check("t5_shift_hold", sh, 0);
    check("t5_pend_hold", pend, 0);
    pcen_n = 0; start = 1; cyc();
    cyc(); lden = 1; cyc(); cyc();
    check("t5_shifting", sh, 1);
    check("t5_pend_set", pend, 1);
    pcen_n = 1; rst = 1; cyc();
    check("t5_rst_pg0", pg0, 0);
    check("t5_rst_shift", sh, 0);
    check("t5_rst_bit", sbit, 0);
    check("t5_rst_cnt", cnt, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_pend", pend, 0);
    rst = 0; pcen_n = 0;

    // Same-cycle write and load of page 0
    ld = 1; wsel = 0; din = 16'h0FFF; cyc();
    ld = 1; wsel = 0; din = 16'h0123; lden = 1; rsel = 0; cyc();
    check("t6_pg0", pg0, 'h123);
    msbf = 0; recirc = 0; start = 1; cyc();
    for (int i = 0; i < 12; i++) begin
      check("t6_prewrite_bit", sbit, 1);
      cyc();
    end

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 299) == 0);
      pcen_n = ($urandom_range(0, 2) == 0);
      ld     = ($urandom_range(0, 7) == 0);
      wsel   = 2'($urandom_range(0, 3));
      din    = 16'($urandom);
      rsel   = 2'($urandom_range(0, 3));
      lden   = ($urandom_range(0, 9) == 0);
      start  = ($urandom_range(0, 5) == 0);
      stop   = ($urandom_range(0, 19) == 0);
      msbf   = ($urandom_range(0, 7) == 0) ? ~msbf : msbf;
      recirc = ($urandom_range(0, 7) == 0) ? ~recirc : recirc;
      cyc();
    end
    rst = 0; pcen_n = 0;
    cyc();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/k005297_pgsr_multi.md
Name: k005297_pgsr_multi

Overview:
- Parametrised successor of the page register / page shift register pair.
- Holds NCH page registers of DW bits and serialises one selected page through a shift register inside a start/stop-delimited shift window.
- Adds: selectable bit order, recirculate or zero-fill mode, a bit counter with auto-stop and done pulse, and deferral of load requests that arrive mid-shift.
- Sits between the CPU data bus and the bubble-memory page-address serial path, clocked from i_MCLK with the 2 MHz positive-phase enable.

Parameters:
DW, 12, page register and shift register width (2..16)
NCH, 4, number of page registers
SELW, 2, page select width, equal to log2(NCH)
CNTW, 5, bit counter width, at least clog2(DW+1)

Ports:
i_MCLK  in  1  master clock
i_SYS_RST  in  1  synchronous active-high reset; honoured on every i_MCLK edge regardless of enable
i_CLK2M_PCEN_n  in  1  active-low clock enable; all non-reset state updates only when low
i_PGREG_LD  in  1  page register write strobe
i_PGREG_WSEL  in  SELW  page register written
i_DIN  in  16  data bus; bits [DW-1:0] used
i_PGREG_RSEL  in  SELW  page register copied into the shift register on load
i_PGREG_SR_LD_EN  in  1  shift register load request
i_SHIFT_START  in  1  opens the shift window
i_SHIFT_STOP  in  1  closes the shift window
i_MODE_MSBF  in  1  0 = LSB first, 1 = MSB first
i_MODE_RECIRC  in  1  1 = output bit re-enters at the fill end, 0 = zero fill
o_PGREG0_Q  out  DW  page register 0 contents (static decode taps)
o_PGREG_SR_SHIFT  out  1  shift window active
o_PGREG_SR_BIT  out  1  serial output bit
o_PGREG_SR_CNT  out  CNTW  bits shifted since last load/start
o_PGREG_SR_DONE  out  1  one-enable-period pulse after the DW-th shift
o_PGREG_LD_PEND  out  1  deferred load outstanding

Behaviour:
- Reset: page registers, shift register, count, shift flag, pending flag and done all go to 0. Reset mid-shift aborts the shift; the pending load is discarded.
- The terms below ("enabled cycle", "next enabled cycle") mean an i_MCLK edge with i_CLK2M_PCEN_n=0.
- Page write:
  - On an enabled cycle with i_PGREG_LD=1: page[WSEL] <= i_DIN[DW-1:0].
  - The write is synchronous; the previous design's transparent latch is replaced.
- Shift flag:
  - Set by START; cleared by STOP or by auto-stop.
  - START and STOP in the same cycle: STOP wins.
  - START while the flag is already set: ignored. START while clear: count <= 0.
- Shift (enabled cycle with the flag set):
  - LSB first: sr <= {fill, sr[DW-1:1]}, and o_PGREG_SR_BIT = sr[0].
  - MSB first: sr <= {sr[DW-2:0], fill}, and o_PGREG_SR_BIT = sr[DW-1].
  - fill = RECIRC ? o_PGREG_SR_BIT : 0.
  - Mode inputs are sampled every enabled cycle and take effect immediately.
- Count and auto-stop:
  - count increments on each shift.
  - The shift that takes count from DW-1 to DW also clears the flag and asserts DONE on the next enabled cycle, for exactly one enable period.
  - count saturates at DW.
- Load:
  - LD_EN with the flag clear: sr <= page[RSEL], count <= 0.
  - LD_EN with the flag set: pend <= 1 and RSEL is captured. The load executes on the first enabled cycle with the flag clear, then pend <= 0.
  - A new LD_EN while pend=1 overwrites the captured RSEL.
  - Load and START in the same cycle with the flag clear: load first, then the flag sets; the first shift happens on the next enabled cycle.
  - Write and load to the same page in the same cycle: the shift register receives the pre-write contents.
- Serial output is combinational from sr and the mode; all other outputs are registered.

Decomposition:
- Package k005297_pkg holds:
  - DW/NCH defaults
  - the bit-order mode encoding (LSBF=0, MSBF=1)
  - the fill mode encoding (ZERO=0, RECIRC=1)
- One sub-module, k005297_pgreg_file: NCH x DW write-port/read-mux register file with the synchronous write and the pre-write read semantics above.

Test Plan:
- Reset, then write page1=0xA5C, load RSEL=1, START, LSB first, zero fill -> serial stream 0,0,1,1,1,0,1,0,0,1,0,1; CNT reaches 12; DONE pulses once; SHIFT drops; sr=0x000.
- Same load with MSB first and recirculate, 12 shifts -> stream 1,0,1,0,0,1,0,1,1,1,0,0; sr returns to 0xA5C.
- LD_EN with RSEL=2 at count 5 during a shift -> LD_PEND=1; after auto-stop, sr=page2 and LD_PEND=0 on the next enabled cycle.
- START and STOP together -> flag stays 0; STOP at count 7 -> count holds 7 with no DONE.
- i_CLK2M_PCEN_n held high with LD/START active -> no state change. SYS_RST asserted mid-shift with the enable high -> all outputs 0 on the next i_MCLK edge.
- Write page0=0x123 and load RSEL=0 in the same cycle (page0 previously 0xFFF) -> sr=0xFFF and o_PGREG0_Q=0x123.
